// File: rtl/fmul_acc_4_4.sv
// fmul_acc_4_4: exact (Kulisch-style) streaming accumulator for 11-bit fmul
// products (exc[1:0], sign, exp[3:0] bias 7, frac[3:0]). A group of operands
// terminated by in_last_i is summed in a signed fixed-point register, then
// renormalised one bit per cycle, rounded to nearest-even and presented on a
// valid/ready output port.
//
// Optional feature macro: FMUL_ACC_COUNT_EN adds out_count_o (beats per group).
//
// Ports:
//   clk_i        clock, all state on posedge
//   rst_n_i      synchronous active-low reset
//   in_data_i    operand, 11 bits
//   in_valid_i   operand valid
//   in_last_i    last operand of the group (qualified by in_valid_i)
//   in_ready_o   stage accepts an operand
//   out_data_o   group sum, same format as in_data_i
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   out_count_o  (FMUL_ACC_COUNT_EN only) accepted beats in the group, saturating
module fmul_acc_4_4 #(
  parameter int unsigned ACC_W = 28,
  parameter int unsigned CNT_W = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [10:0] in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [10:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
`ifdef FMUL_ACC_COUNT_EN
  ,
  output logic [15:0] out_count_o
`endif
);

  localparam int unsigned MSB = ACC_W - 1;
  localparam int unsigned EW  = CNT_W + 2;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   mag_q;
  logic [CNT_W-1:0]   pos_q;
  logic               nan_q, inf_p_q, inf_n_q, ovf_q, ovf_sign_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [10:0]        out_data_q;

  // Operand decode and exact term generation
  logic [1:0]         exc_d;
  logic               sgn_d;
  logic [3:0]         exp_d;
  logic [3:0]         frac_d;
  logic [ACC_W-1:0]   term_mag_d;
  logic [ACC_W-1:0]   term_d;
  logic [ACC_W-1:0]   sum_d;
  logic               add_ovf_d;
  logic [ACC_W-1:0]   acc_d;
  logic [ACC_W-1:0]   abs_d;
  logic               accept_d;
  logic               xfer_d;

  always_comb begin
    exc_d      = in_data_i[10:9];
    sgn_d      = in_data_i[8];
    exp_d      = in_data_i[7:4];
    frac_d     = in_data_i[3:0];
    // {1,frac} << exp with LSB weight 2^-11
    term_mag_d = ACC_W'({1'b1, frac_d}) << exp_d;
    term_d     = sgn_d ? (~term_mag_d + ACC_W'(1)) : term_mag_d;
    sum_d      = acc_q + term_d;
    add_ovf_d  = (acc_q[MSB] == term_d[MSB]) && (sum_d[MSB] != acc_q[MSB]);
    // Accumulator value including this beat, used to load the normaliser on in_last
    acc_d      = (exc_d == EXC_NORM) ? sum_d : acc_q;
    abs_d      = acc_d[MSB] ? (~acc_d + ACC_W'(1)) : acc_d;
    accept_d   = in_valid_i & in_ready_q;
    xfer_d     = out_valid_q & out_ready_i;
  end

  // Round-to-nearest-even of the normalised magnitude (leading one at mag_q[MSB])
  logic [3:0]    rfrac_d;
  logic          guard_d;
  logic          sticky_d;
  logic          rnd_d;
  logic [4:0]    frac5_d;
  logic [EW-1:0] e_d;
  logic          e_neg_d;
  logic          e_big_d;
  logic          acc_sign_d;
  logic [10:0]   res_d;

  always_comb begin
    rfrac_d    = mag_q[ACC_W-2 -: 4];
    guard_d    = mag_q[ACC_W-6];
    sticky_d   = |mag_q[ACC_W-7:0];
    rnd_d      = guard_d & (sticky_d | rfrac_d[0]);
    frac5_d    = {1'b0, rfrac_d} + 5'(rnd_d);
    // Two spare bits keep pos-4 representable as a two's-complement value
    e_d        = EW'(pos_q) - EW'(4) + EW'(frac5_d[4]);
    e_neg_d    = e_d[EW-1];
    e_big_d    = !e_neg_d && (e_d > EW'(15));
    acc_sign_d = acc_q[MSB];
    res_d      = 11'h000;
    if (nan_q || (inf_p_q && inf_n_q)) begin
      res_d = 11'h600;
    end else if (inf_p_q) begin
      res_d = 11'h400;
    end else if (inf_n_q) begin
      res_d = 11'h500;
    end else if (ovf_q) begin
      res_d = {EXC_INF, ovf_sign_q, 8'h00};
    end else if (mag_q == '0) begin
      res_d = 11'h000;
    end else if (e_neg_d) begin
      res_d = 11'h000;
    end else if (e_big_d) begin
      res_d = {EXC_INF, acc_sign_d, 8'h00};
    end else begin
      res_d = {EXC_NORM, acc_sign_d, e_d[3:0], frac5_d[3:0]};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_ACCUM;
      acc_q       <= '0;
      mag_q       <= '0;
      pos_q       <= '0;
      nan_q       <= 1'b0;
      inf_p_q     <= 1'b0;
      inf_n_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ovf_sign_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept_d) begin
            case (exc_d)
              EXC_NORM: begin
                acc_q <= sum_d;
                if (add_ovf_d) begin
                  ovf_q      <= 1'b1;
                  ovf_sign_q <= sgn_d;
                end
              end
              EXC_INF: begin
                if (sgn_d) inf_n_q <= 1'b1;
                else       inf_p_q <= 1'b1;
              end
              EXC_NAN:  nan_q <= 1'b1;
              EXC_ZERO: ;
              default:  ;
            endcase
            if (in_last_i) begin
              mag_q      <= abs_d;
              pos_q      <= CNT_W'(ACC_W - 1);
              in_ready_q <= 1'b0;
              state_q    <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (mag_q[MSB] || (mag_q == '0)) begin
            state_q <= S_ROUND;
          end else begin
            mag_q <= mag_q << 1;
            pos_q <= pos_q - CNT_W'(1);
          end
        end
        S_ROUND: begin
          out_data_q  <= res_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (xfer_d) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            nan_q       <= 1'b0;
            inf_p_q     <= 1'b0;
            inf_n_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_sign_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_ACCUM;
          end
        end
        default: state_q <= S_ACCUM;
      endcase
    end
  end

  // in_ready must drop as soon as reset is asserted, not one edge later
  assign in_ready_o  = in_ready_q & rst_n_i;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

`ifdef FMUL_ACC_COUNT_EN
  // Beats accepted in the current group, saturating
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (xfer_d) begin
      cnt_q <= '0;
    end else if (accept_d && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_count_o = cnt_q;
`else
  // No beat counter in this build.
`endif

endmodule
